track_rv_fifo: RTL and testbench
================================

# track_rv_fifo

Ready/valid FIFO register on a routing track, placed directly upstream of the fanout ready-combiner. It drives one track's data/valid to all configured consumers. It takes as `out_ready` the combiner's AND of per-consumer "disabled, not selected, or ready" terms. It decouples the upstream producer from the consumers' combined ready, with one cycle of latency and no combinational path from `out_ready` to `in_ready` in buffered mode.

## Interface
Parameters:
- `WIDTH`, 16: data bits per token.
- `DEPTH`, 2: entries; power of two, ≥2.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `flush` in 1: synchronous clear of contents.
- `cfg_fifo_en` in 1: 1 = buffered mode, 0 = combinational pass-through.
- `in_data` in WIDTH: producer data.
- `in_valid` in 1: producer valid.
- `in_ready` out 1: FIFO can accept.
- `out_data` out WIDTH: head entry, fanned out to consumers.
- `out_valid` out 1: head valid.
- `out_ready` in 1: combined consumer ready from the fanout combiner.
- `stall_cycles` out 32: present only with the macro, see Configuration.

## Operation
- State: `count` (0..DEPTH), `wr_ptr`, `rd_ptr` (log2(DEPTH) bits, natural wrap), storage array.
- Buffered mode (`cfg_fifo_en`=1):
  - Push when `in_valid & in_ready`; pop when `out_valid & out_ready`.
  - `in_ready` = (`count` != DEPTH). It depends only on state.
  - `out_valid` = (`count` != 0); `out_data` = `mem[rd_ptr]`.
  - Simultaneous push and pop: `count` unchanged, both pointers advance.
  - Full: `in_ready`=0, so a same-cycle pop does not admit a push. The next cycle `in_ready`=1.
  - Empty: no bypass. A pushed token appears on `out_valid` the next cycle.
  - Wrap-around: pointers wrap modulo DEPTH; full and empty are distinguished by `count`.
  - `out_data` is stable while `out_valid & !out_ready`. Once `out_valid` is asserted, it holds until the pop.
- Pass-through mode (`cfg_fifo_en`=0):
  - `out_data`=`in_data`, `out_valid`=`in_valid`, `in_ready`=`out_ready`.
  - `count` and pointers are forced to 0 every cycle; no tokens are retained.
- `cfg_fifo_en` is changed only while the track is idle. A change while non-empty discards contents on the next edge; this is defined behaviour, not an error.
- `flush`: the next edge sets `count`, `wr_ptr` and `rd_ptr` to 0. A push in the same cycle is dropped. `flush` has priority over push and pop.
- Reset (async): `count`=0, pointers=0, `out_valid`=0, `in_ready`=1 in buffered mode, `stall_cycles`=0. Storage is not reset; `out_data` is don't-care while `out_valid`=0.
- Reset asserted mid-transfer: all tokens are lost. Release is synchronous to `clk` by the system.

## Timing
- Buffered: input-to-output latency is 1 cycle; throughput is 1 token/cycle sustained with DEPTH≥2.
- Backpressure: when `out_ready` deasserts with the FIFO empty, DEPTH further tokens are accepted before `in_ready` falls.
- `in_ready` is registered-state-derived, with no combinational `out_ready`→`in_ready` path in buffered mode.
- Pass-through: zero latency, fully combinational.

## Configuration
- Macro: `TRACK_RV_FIFO_STALL_CNT_EN`.
- Defined:
  - The `stall_cycles` port exists.
  - It increments every cycle in which `out_valid & !out_ready` holds, in either mode.
  - It saturates at 32'hFFFF_FFFF and is cleared by `reset` or `flush`.
- Undefined: the port and counter logic are absent; all other behaviour is identical.

## Structure
- Shared package `track_rv_fifo_pkg`:
  - `PTR_W` function (clog2 of DEPTH).
  - `STALL_CNT_W`=32.
  - `STALL_CNT_MAX` constant.
- One natural sub-module: `track_rv_fifo_stall_cnt`, the saturating counter, instantiated only under the macro.
- Storage and pointer logic stay in the top module.

## Test plan
- Reset then idle: `out_valid`=0, `in_ready`=1, `count`=0. With the macro, `stall_cycles`=0.
- Stream 0x0001..0x0008 with `out_ready`=1 held: outputs appear 1 cycle after input, in order, with no bubbles.
- Hold `out_ready`=0 and push 0xA, 0xB, 0xC:
  - `in_ready` falls after 2 accepts; 0xC is held upstream.
  - With the macro, `stall_cycles` counts each stalled cycle.
  - Release `out_ready`: 0xA, 0xB, 0xC come out in order.
- Full FIFO with push and pop in the same cycle:
  - The pop occurs and the push is refused (`in_ready`=0).
  - The next cycle accepts; pointer wrap is verified over 3 full cycles.
- Assert `flush` while holding 2 entries with `in_valid`=1: the next cycle `out_valid`=0, `count`=0, and the in-flight token is dropped.
- `cfg_fifo_en`=0 with `out_ready` toggling: `in_ready` mirrors `out_ready` and `out_data`=`in_data` in the same cycle.

Source files
------------

// File: rtl/track_rv_fifo_pkg.sv
// track_rv_fifo_pkg
//   Shared definitions for the routing-track ready/valid FIFO.
//   - PTR_W(depth)  : pointer width for a power-of-two depth
//   - STALL_CNT_W   : width of the optional stall counter
//   - STALL_CNT_MAX : saturation value of the stall counter
//   - fifo_mode_e   : decoded cfg_fifo_en (pass-through / buffered)
package track_rv_fifo_pkg;

  localparam int STALL_CNT_W = 32;
  localparam logic [STALL_CNT_W-1:0] STALL_CNT_MAX = 32'hFFFF_FFFF;

  typedef enum logic {
    MODE_PASS     = 1'b0,
    MODE_BUFFERED = 1'b1
  } fifo_mode_e;

  // A depth of one would give a zero-width pointer, so clamp to one bit.
  function automatic int PTR_W(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/track_rv_fifo_stall_cnt.sv
// track_rv_fifo_stall_cnt
//   Saturating cycle counter used to measure how long the track's head
//   token waits on the fanout consumers.
//   Ports:
//     clk   in  : clock, rising edge
//     reset in  : asynchronous active-high reset, clears the count
//     clear in  : synchronous clear (has priority over inc)
//     inc   in  : count this cycle
//     count out : current count, sticks at STALL_CNT_MAX
module track_rv_fifo_stall_cnt
  import track_rv_fifo_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   inc,
  output logic [STALL_CNT_W-1:0] count
);

  // Counter holds at its maximum rather than wrapping, so a long stall
  // never reads back as a short one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != STALL_CNT_MAX)) begin
      count <= count + STALL_CNT_W'(1);
    end
  end

endmodule

// File: rtl/track_rv_fifo.sv
// track_rv_fifo
//   Ready/valid FIFO register on a routing track, feeding the fanout
//   ready-combiner. In buffered mode it gives one cycle of latency and
//   in_ready depends only on the occupancy, never on out_ready. In
//   pass-through mode the track is a plain wire and nothing is stored.
//   Optional feature: define TRACK_RV_FIFO_STALL_CNT_EN to add the
//   stall_cycles port and its saturating counter.
//   Ports:
//     clk          in  : clock, rising edge
//     reset        in  : asynchronous active-high reset
//     flush        in  : synchronous clear of contents
//     cfg_fifo_en  in  : 1 = buffered, 0 = pass-through
//     in_data      in  : producer data
//     in_valid     in  : producer valid
//     in_ready     out : FIFO can accept
//     out_data     out : head entry to consumers
//     out_valid    out : head valid
//     out_ready    in  : combined consumer ready
//     stall_cycles out : cycles with out_valid & !out_ready (macro only)
module track_rv_fifo
  import track_rv_fifo_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   cfg_fifo_en,
  input  logic [WIDTH-1:0]       in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_valid,
  input  logic                   out_ready
`ifdef TRACK_RV_FIFO_STALL_CNT_EN
  ,
  output logic [STALL_CNT_W-1:0] stall_cycles
`endif
);

  localparam int PW = PTR_W(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;

  fifo_mode_e mode;
  logic       buffered;
  logic       buf_in_ready;
  logic       buf_out_valid;
  logic       push;
  logic       pop;

  assign mode          = fifo_mode_e'(cfg_fifo_en);
  assign buffered      = (mode == MODE_BUFFERED);
  assign buf_in_ready  = (count != FULL_CNT);
  assign buf_out_valid = (count != '0);

  // Handshakes only matter in buffered mode; in pass-through the
  // storage is bypassed entirely.
  assign push = buffered & in_valid & buf_in_ready;
  assign pop  = buffered & buf_out_valid & out_ready;

  assign in_ready  = buffered ? buf_in_ready  : out_ready;
  assign out_valid = buffered ? buf_out_valid : in_valid;
  assign out_data  = buffered ? mem[rd_ptr]   : in_data;

  // Occupancy and pointers. Flush and pass-through both empty the FIFO
  // on the next edge, which is also how a mode change mid-stream drops
  // whatever was held. Pointers wrap naturally since DEPTH is 2^PW.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush || !buffered) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is deliberately unreset; out_data is only meaningful while
  // out_valid is high. A push in a flush cycle is dropped.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr] <= in_data;
    end
  end

`ifdef TRACK_RV_FIFO_STALL_CNT_EN
  track_rv_fifo_stall_cnt u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (flush),
    .inc   (out_valid & ~out_ready),
    .count (stall_cycles)
  );
`endif

endmodule

// File: tb/tb_track_rv_fifo.sv
// tb_track_rv_fifo
//   Directed bench for track_rv_fifo (WIDTH=16, DEPTH=2). A queue model
//   tracks what the track must be holding and is compared against the
//   DUT every cycle; directed steps add hand-computed literal checks.
module tb_track_rv_fifo;

  localparam int WIDTH = 16;
  localparam int DEPTH = 2;

  logic             clk;
  logic             reset;
  logic             flush;
  logic             cfg_fifo_en;
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
`ifdef TRACK_RV_FIFO_STALL_CNT_EN
  logic [31:0]      stall_cycles;
`endif

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] mq[$];
  logic [31:0]      mstall;

  track_rv_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .flush        (flush),
    .cfg_fifo_en  (cfg_fifo_en),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready)
`ifdef TRACK_RV_FIFO_STALL_CNT_EN
    ,
    .stall_cycles (stall_cycles)
`endif
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle's inputs just after the rising edge, then return at
  // the falling edge so the caller can inspect that cycle's outputs.
  task automatic applyStimulus(input logic v, input logic [WIDTH-1:0] d, input logic r,
                               input logic f, input logic en);
    @(posedge clk);
    #1;
    in_valid    = v;
    in_data     = d;
    out_ready   = r;
    flush       = f;
    cfg_fifo_en = en;
    @(negedge clk);
  endtask

  // Queue model: the FIFO is a list of at most DEPTH tokens. Outputs are
  // read off the list, then the list is advanced by this cycle's rules.
  always @(negedge clk) begin
    logic             e_ir, e_ov, take, acc;
    logic [WIDTH-1:0] e_od;
    if (reset) begin
      mq.delete();
      mstall = '0;
    end else begin
      if (cfg_fifo_en) begin
        e_ir = (mq.size() < DEPTH);
        e_ov = (mq.size() > 0);
        e_od = e_ov ? mq[0] : '0;
      end else begin
        e_ir = out_ready;
        e_ov = in_valid;
        e_od = in_data;
      end
      checkOutput("model in_ready", {31'd0, in_ready}, {31'd0, e_ir});
      checkOutput("model out_valid", {31'd0, out_valid}, {31'd0, e_ov});
      if (e_ov) checkOutput("model out_data", {16'd0, out_data}, {16'd0, e_od});
`ifdef TRACK_RV_FIFO_STALL_CNT_EN
      checkOutput("model stall_cycles", stall_cycles, mstall);
`endif
      if (flush) mstall = '0;
      else if (e_ov && !out_ready && mstall != 32'hFFFF_FFFF) mstall = mstall + 1;
      if (flush || !cfg_fifo_en) begin
        mq.delete();
      end else begin
        take = e_ov && out_ready;
        acc  = in_valid && e_ir;
        if (take) void'(mq.pop_front());
        if (acc) mq.push_back(in_data);
      end
    end
  end

  initial begin
    reset       = 1'b1;
    flush       = 1'b0;
    cfg_fifo_en = 1'b1;
    in_data     = '0;
    in_valid    = 1'b0;
    out_ready   = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset then idle
    applyStimulus(0, 16'h0, 0, 0, 1);
    checkOutput("reset out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("reset in_ready", {31'd0, in_ready}, 32'd1);
`ifdef TRACK_RV_FIFO_STALL_CNT_EN
    checkOutput("reset stall_cycles", stall_cycles, 32'd0);
`endif

    // Stream 1..8 with out_ready held: one cycle latency, no bubbles
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(1, 16'(i), 1, 0, 1);
      checkOutput("stream in_ready", {31'd0, in_ready}, 32'd1);
      if (i == 1) begin
        checkOutput("stream first empty", {31'd0, out_valid}, 32'd0);
      end else begin
        checkOutput("stream out_valid", {31'd0, out_valid}, 32'd1);
        checkOutput("stream out_data", {16'd0, out_data}, 32'(i - 1));
      end
    end
    applyStimulus(0, 16'h0, 1, 0, 1);
    checkOutput("stream last data", {16'd0, out_data}, 32'h0008);
    applyStimulus(0, 16'h0, 1, 0, 1);
    checkOutput("stream drained", {31'd0, out_valid}, 32'd0);

    // Backpressure: A and B accepted, C held upstream
    applyStimulus(1, 16'h000A, 0, 0, 1);
    checkOutput("bp accept A", {31'd0, in_ready}, 32'd1);
    applyStimulus(1, 16'h000B, 0, 0, 1);
    checkOutput("bp accept B", {31'd0, in_ready}, 32'd1);
    applyStimulus(1, 16'h000C, 0, 0, 1);
    checkOutput("bp full", {31'd0, in_ready}, 32'd0);
    applyStimulus(1, 16'h000C, 0, 0, 1);
    checkOutput("bp head held", {16'd0, out_data}, 32'h000A);
`ifdef TRACK_RV_FIFO_STALL_CNT_EN
    checkOutput("bp stall count", stall_cycles, 32'd2);
`endif
    applyStimulus(1, 16'h000C, 1, 0, 1);
    checkOutput("bp out A", {16'd0, out_data}, 32'h000A);
    checkOutput("bp full refuse", {31'd0, in_ready}, 32'd0);
    applyStimulus(1, 16'h000C, 1, 0, 1);
    checkOutput("bp out B", {16'd0, out_data}, 32'h000B);
    checkOutput("bp accept C", {31'd0, in_ready}, 32'd1);
    applyStimulus(0, 16'h0, 1, 0, 1);
    checkOutput("bp out C", {16'd0, out_data}, 32'h000C);
    applyStimulus(0, 16'h0, 1, 0, 1);
    checkOutput("bp drained", {31'd0, out_valid}, 32'd0);

    // Full with push and pop together, three rounds to exercise wrap
    for (int r = 0; r < 3; r++) begin
      applyStimulus(1, 16'(16'h0100 + 16'(r * 16) + 16'd1), 0, 0, 1);
      applyStimulus(1, 16'(16'h0100 + 16'(r * 16) + 16'd2), 0, 0, 1);
      applyStimulus(1, 16'(16'h0100 + 16'(r * 16) + 16'd3), 1, 0, 1);
      checkOutput("wrap full refuse", {31'd0, in_ready}, 32'd0);
      checkOutput("wrap head a", {16'd0, out_data}, 32'(16'h0100 + 16'(r * 16) + 16'd1));
      applyStimulus(1, 16'(16'h0100 + 16'(r * 16) + 16'd3), 1, 0, 1);
      checkOutput("wrap accept", {31'd0, in_ready}, 32'd1);
      checkOutput("wrap head b", {16'd0, out_data}, 32'(16'h0100 + 16'(r * 16) + 16'd2));
      applyStimulus(0, 16'h0, 1, 0, 1);
      checkOutput("wrap head c", {16'd0, out_data}, 32'(16'h0100 + 16'(r * 16) + 16'd3));
      applyStimulus(0, 16'h0, 0, 0, 1);
      checkOutput("wrap empty", {31'd0, out_valid}, 32'd0);
    end

    // Flush with two entries held and a token offered
    applyStimulus(1, 16'h0077, 0, 0, 1);
    applyStimulus(1, 16'h0088, 0, 0, 1);
    applyStimulus(1, 16'h0099, 0, 1, 1);
    applyStimulus(0, 16'h0, 1, 0, 1);
    checkOutput("flush out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("flush in_ready", {31'd0, in_ready}, 32'd1);
`ifdef TRACK_RV_FIFO_STALL_CNT_EN
    checkOutput("flush stall clear", stall_cycles, 32'd0);
`endif
    // Flush while empty drops the same-cycle push
    applyStimulus(1, 16'h00EE, 0, 1, 1);
    applyStimulus(0, 16'h0, 0, 0, 1);
    checkOutput("flush drops push", {31'd0, out_valid}, 32'd0);

    // Pass-through with out_ready toggling
    for (int k = 0; k < 6; k++) begin
      applyStimulus(logic'(k % 2), 16'(16'h0300 + 16'(k)), logic'((k / 2) % 2), 0, 0);
      checkOutput("pass in_ready", {31'd0, in_ready}, 32'((k / 2) % 2));
      checkOutput("pass out_data", {16'd0, out_data}, 32'(16'h0300 + 16'(k)));
      checkOutput("pass out_valid", {31'd0, out_valid}, 32'(k % 2));
    end

    // Back to buffered: nothing retained; then a held token is discarded
    // by a mode change
    applyStimulus(0, 16'h0, 0, 0, 1);
    checkOutput("mode back empty", {31'd0, out_valid}, 32'd0);
    applyStimulus(1, 16'h0ABC, 0, 0, 1);
    applyStimulus(0, 16'h0, 0, 0, 0);
    applyStimulus(0, 16'h0, 0, 0, 1);
    checkOutput("mode change discard", {31'd0, out_valid}, 32'd0);

    applyStimulus(0, 16'h0, 1, 0, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
